// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the two-requester single-port RAM arbiter.
// The request struct is sized for the default 32 KiB x 32-bit configuration.
package sp_ram_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 15;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer register
// that moves to the other requester whenever a grant is taken.
module rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       taken_i,
    output logic [1:0] gnt_o
);

    master_id_e ptr_q;
    master_id_e ptr_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_q == M0) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (taken_i) begin
            ptr_d = gnt_o[0] ? M1 : M0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            ptr_q <= M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between a core data port (M0) and a debug/DMA port (M1),
// optionally zero-filling the RAM after reset before any request is granted.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned DATA_WIDTH = MEM_DATA_W,
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic                    clk,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

    output logic                    init_done_o
);

    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
    localparam int unsigned BYTE_OFF_W = $clog2(BE_WIDTH);
    localparam int unsigned NUM_WORDS  = RAM_SIZE / BE_WIDTH;
    localparam int unsigned WORD_CNT_W = ADDR_WIDTH - BYTE_OFF_W;
    localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(NUM_WORDS - 1);

    arb_state_e            state_q, state_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  valid_q, valid_d;
    master_id_e            owner_q, owner_d;
    logic                  rd_q, rd_d;

    logic                  run_ok;
    logic [1:0]            arb_req;
    logic [1:0]            arb_gnt;
    mem_req_t              m0_req, m1_req, win_req;

    // Grants are only offered in RUN and never while reset is being applied.
    assign run_ok  = (state_q == RUN) && !rst_i;
    assign arb_req = {m1_req_i, m0_req_i} & {2{run_ok}};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_i   (rst_i),
        .req_i   (arb_req),
        .taken_i (|arb_gnt),
        .gnt_o   (arb_gnt)
    );

    assign m0_gnt_o = arb_gnt[0];
    assign m1_gnt_o = arb_gnt[1];

    assign m0_req  = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign m1_req  = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
    assign win_req = arb_gnt[1] ? m1_req : m0_req;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        valid_d     = |arb_gnt;
        owner_d     = owner_q;
        rd_d        = rd_q;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;

        case (state_q)
            INIT: begin
                if (!rst_i) begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_be_o   = '1;
                    ram_addr_o = {word_cnt_q, {BYTE_OFF_W{1'b0}}};
                    word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (|arb_gnt) begin
                    ram_en_o    = 1'b1;
                    ram_we_o    = win_req.we;
                    ram_be_o    = win_req.be;
                    ram_addr_o  = win_req.addr;
                    ram_wdata_o = win_req.wdata;
                    owner_d     = arb_gnt[1] ? M1 : M0;
                    rd_d        = !win_req.we;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= (INIT_ZERO != 0) ? INIT : RUN;
            word_cnt_q <= '0;
            valid_q    <= 1'b0;
            owner_q    <= M0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            rd_q       <= rd_d;
        end
    end

    // Read data is steered only to the owner of a valid read; writes answer with zero.
    assign m0_rvalid_o = valid_q && (owner_q == M0);
    assign m1_rvalid_o = valid_q && (owner_q == M1);
    assign m0_rdata_o  = (m0_rvalid_o && rd_q) ? ram_rdata_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o && rd_q) ? ram_rdata_i : '0;
    assign init_done_o = run_ok;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level memory/round-robin model.
module tb_sp_ram_arbiter;

    localparam int unsigned RAM_SIZE = 32768;
    localparam int unsigned AW       = 15;
    localparam int unsigned DW       = 32;
    localparam int unsigned BW       = DW / 8;
    localparam int unsigned NW       = RAM_SIZE / BW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic [1:0]    req;
    logic [AW-1:0] addr [2];
    logic [1:0]    we;
    logic [BW-1:0] be [2];
    logic [DW-1:0] wd [2];
    logic [1:0]    gnt, rvalid;
    logic [DW-1:0] rdata [2];
    logic          ram_en, ram_we, init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [BW-1:0] ram_be;

    logic          nz_req;
    logic [1:0]    nz_gnt, nz_rvalid;
    logic [DW-1:0] nz_rdata [2];
    logic          nz_en, nz_we, nz_init_done;
    logic [AW-1:0] nz_addr;
    logic [DW-1:0] nz_wdata;
    logic [BW-1:0] nz_be;

    sp_ram_arbiter #(.RAM_SIZE(RAM_SIZE), .INIT_ZERO(1)) u_dut (
        .clk(clk), .rst_i(rst_i),
        .m0_req_i(req[0]), .m0_addr_i(addr[0]), .m0_we_i(we[0]), .m0_be_i(be[0]), .m0_wdata_i(wd[0]),
        .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]), .m0_rdata_o(rdata[0]),
        .m1_req_i(req[1]), .m1_addr_i(addr[1]), .m1_we_i(we[1]), .m1_be_i(be[1]), .m1_wdata_i(wd[1]),
        .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]), .m1_rdata_o(rdata[1]),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_rdata_i(ram_rdata), .init_done_o(init_done)
    );

    sp_ram_arbiter #(.RAM_SIZE(RAM_SIZE), .INIT_ZERO(0)) u_dut_nz (
        .clk(clk), .rst_i(rst_i),
        .m0_req_i(nz_req), .m0_addr_i('0), .m0_we_i(1'b0), .m0_be_i('1), .m0_wdata_i('0),
        .m0_gnt_o(nz_gnt[0]), .m0_rvalid_o(nz_rvalid[0]), .m0_rdata_o(nz_rdata[0]),
        .m1_req_i(1'b0), .m1_addr_i('0), .m1_we_i(1'b0), .m1_be_i('0), .m1_wdata_i('0),
        .m1_gnt_o(nz_gnt[1]), .m1_rvalid_o(nz_rvalid[1]), .m1_rdata_o(nz_rdata[1]),
        .ram_en_o(nz_en), .ram_addr_o(nz_addr), .ram_wdata_o(nz_wdata), .ram_we_o(nz_we),
        .ram_be_o(nz_be), .ram_rdata_i('0), .init_done_o(nz_init_done)
    );

    // RAM behind the arbiter; reset preloads non-zero garbage so zero-fill is visible.
    logic [DW-1:0] ram_mem [NW];
    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < NW; i++) ram_mem[i] <= 32'hA5A5_0000 | DW'(i);
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be[b]) ram_mem[ram_addr[AW-1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr[AW-1:2]];
            end
        end
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state: expected memory, tie-break owner, pending responses.
    logic [DW-1:0] exp_mem [NW];
    int            ptr;
    logic [1:0]    exp_v;
    logic [DW-1:0] exp_d [2];
    logic [1:0]    obs_gnt, obs_rv;
    logic [DW-1:0] obs_rd [2];
    logic [BW-1:0] obs_be;
    logic          obs_en;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic issue(input int m, input logic w, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [DW-1:0] d);
        req[m]  = 1'b1;
        we[m]   = w;
        addr[m] = a;
        be[m]   = b;
        wd[m]   = d;
    endtask

    // One RUN cycle: check outputs mid-cycle against the model, then advance past the edge.
    task automatic run_cycle();
        int         win;
        logic [1:0] exp_gnt;
        @(negedge clk);
        obs_gnt   = gnt;
        obs_rv    = rvalid;
        obs_rd[0] = rdata[0];
        obs_rd[1] = rdata[1];
        obs_be    = ram_be;
        obs_en    = ram_en;
        check("rvalid", rvalid, exp_v);
        for (int m = 0; m < 2; m++)
            if (exp_v[m]) check($sformatf("rdata%0d", m), rdata[m], exp_d[m]);
        check("init_done", init_done, 1'b1);
        if (req == 2'b11)  win = ptr;
        else if (req[0])   win = 0;
        else if (req[1])   win = 1;
        else               win = -1;
        exp_gnt = (win < 0) ? 2'b00 : 2'(1 << win);
        check("gnt", gnt, exp_gnt);
        check("ram_en", ram_en, win >= 0);
        exp_v = exp_gnt;
        if (win >= 0) begin
            check("ram_addr", ram_addr, addr[win]);
            check("ram_we_be", {ram_we, ram_be}, {we[win], be[win]});
            if (we[win]) begin
                check("ram_wdata", ram_wdata, wd[win]);
                exp_mem[addr[win][AW-1:2]] = merge(exp_mem[addr[win][AW-1:2]], wd[win], be[win]);
                exp_d[win] = '0;
            end else begin
                exp_d[win] = exp_mem[addr[win][AW-1:2]];
            end
            ptr = 1 - win;
        end
        @(posedge clk);
        #1;
        if (win >= 0) req[win] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && req != 2'b00; i++) run_cycle();
        check("drain_timeout", req, 2'b00);
        run_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i  = 1'b1;
        req    = 2'b00;
        nz_req = 1'b1;
        ptr    = 0;
        exp_v  = 2'b00;
        for (int m = 0; m < 2; m++) begin
            addr[m] = '0; we[m] = 1'b0; be[m] = '0; wd[m] = '0; exp_d[m] = '0;
        end
        // M0 raises a read of word 0 during reset/INIT; it must wait for RUN.
        issue(0, 1'b0, '0, '1, '0);

        @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 2'b00);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_rdata0", rdata[0], '0);
        check("rst_rdata1", rdata[1], '0);
        check("rst_ram_en_we", {ram_en, ram_we}, 2'b00);
        check("rst_init_done", init_done, 1'b0);
        check("rst_nz_init_done", nz_init_done, 1'b0);
        check("rst_nz_gnt", nz_gnt, 2'b00);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Zero-fill sweep.
        for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            check("init_addr", ram_addr, AW'(k * BW));
            check("init_ctl", {ram_en, ram_we, ram_be, gnt}, {1'b1, 1'b1, 4'hF, 2'b00});
            check("init_wdata", ram_wdata, '0);
            check("init_done_low", init_done, 1'b0);
            if (k == 0) begin
                check("nz_first_gnt", nz_gnt, 2'b01);
                check("nz_first_init_done", nz_init_done, 1'b1);
            end
            if (k == 1) begin
                check("nz_rvalid", nz_rvalid, 2'b01);
                check("nz_init_done", nz_init_done, 1'b1);
            end
            @(posedge clk);
            #1;
            if (k == 1) nz_req = 1'b0;
        end
        for (int i = 0; i < NW; i++) exp_mem[i] = '0;

        run_cycle();
        check("t1_run_gnt", obs_gnt, 2'b01);
        run_cycle();

        // M0 alone: write then read back.
        issue(0, 1'b1, AW'('h10), 4'hF, 32'hDEADBEEF);
        run_cycle();
        check("t2_wr_gnt", obs_gnt, 2'b01);
        issue(0, 1'b0, AW'('h10), 4'hF, '0);
        run_cycle();
        check("t2_rd_gnt", obs_gnt, 2'b01);
        check("t2_wr_rvalid", obs_rv, 2'b01);
        run_cycle();
        check("t2_rd_rvalid", obs_rv, 2'b01);
        check("t2_rd_data", obs_rd[0], 32'hDEADBEEF);

        // Steer the pointer back to M0, then contend for six cycles.
        issue(1, 1'b0, AW'('h10), 4'hF, '0);
        drain();
        for (int i = 0; i < 6; i++) begin
            for (int m = 0; m < 2; m++)
                if (!req[m]) issue(m, 1'b0, AW'(4 * (i + m)), 4'hF, '0);
            run_cycle();
            check("t3_gnt", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("t3_en", obs_en, 1'b1);
            if (i > 0) check("t3_rvalid", obs_rv, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        drain();

        // Partial write from M1 over a full word, read back by M0.
        issue(0, 1'b1, AW'('h20), 4'hF, 32'h12345678);
        run_cycle();
        issue(1, 1'b1, AW'('h20), 4'b0001, 32'h000000AA);
        run_cycle();
        check("t4_be", obs_be, 4'b0001);
        issue(0, 1'b0, AW'('h20), 4'hF, '0);
        run_cycle();
        run_cycle();
        check("t4_rd", obs_rd[0], 32'h123456AA);

        // Randomized traffic against the model.
        repeat (400) begin
            for (int m = 0; m < 2; m++)
                if (!req[m] && ($urandom_range(0, 9) < 6))
                    issue(m, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                          BW'($urandom_range(0, 15)), $urandom());
            run_cycle();
        end
        drain();

        // Reset in the cycle after an M0 read grant.
        issue(0, 1'b0, AW'('h10), 4'hF, '0);
        run_cycle();
        check("t5_gnt", obs_gnt, 2'b01);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("t5_rvalid", rvalid, 2'b00);
        check("t5_init_done", init_done, 1'b0);
        check("t5_word0", {ram_en, ram_we, ram_addr}, {1'b1, 1'b1, AW'(0)});
        check("t5_nz_init_done", nz_init_done, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_word1", ram_addr, AW'(BW));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
